// File: rtl/mac_ctrl_pkg.sv
// Shared types and instruction encodings for the MAC array sequencer.
package mac_ctrl_pkg;

  // Job phases, in the order a weight-stationary job walks through them.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KLOAD  = 3'd1,
    S_KFLUSH = 3'd2,
    S_EXEC   = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // inst_w encodings seen by the array; 2'b11 is never produced.
  localparam logic [1:0] INST_NOP   = 2'b00;
  localparam logic [1:0] INST_KLOAD = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;

endpackage

// File: rtl/mac_ctrl_cnt.sv
// Loadable down-counter with enable and zero flag; holds at zero instead of wrapping.
module mac_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over decrement; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for the 2D MAC array: kernel load, execute, drain, done per start pulse.
// Valid/ready: the array consumes one IFIFO word in every cycle inst_w is non-zero
// (ififo_rd mirrors that), and an OFIFO column accepts a word whenever arr_valid
// is high and that column is not full; a valid word hitting a full column is lost
// and recorded in ovf.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [cnt_bw-1:0] num_vec,
  input  logic              ififo_empty,
  input  logic [col-1:0]    ofifo_full,
  input  logic [col-1:0]    arr_valid,
  output logic [1:0]        inst_w,
  output logic              weight_or_out,
  output logic              ififo_rd,
  output logic [col-1:0]    ofifo_wr,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [2:0]        dbg_state
);

  localparam int DRAIN_LEN = row + col + 1;
  localparam int PH_W      = $clog2(DRAIN_LEN + 1);
  localparam logic [PH_W-1:0]   PH_ONE  = PH_W'(1);
  localparam logic [cnt_bw-1:0] VEC_ONE = cnt_bw'(1);

  // state_q is the phase whose outputs are being decided this cycle; the
  // registered outputs it produces appear one cycle later.
  state_e            state_q, state_d, cur_ph, nxt_ph;
  logic              mode_q, mode_d;
  logic [cnt_bw-1:0] num_vec_q, num_vec_d;
  logic [1:0]        inst_w_q, inst_w_d;
  logic              wo_q, wo_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;

  logic              start_acc, mode_eff, nv_zero, go, last;
  logic [cnt_bw-1:0] nv_eff, vec_rem, vec_cnt, vec_val;
  logic [PH_W-1:0]   ph_rem, ph_cnt, ph_val;
  logic              ph_load, ph_en, vec_load, vec_en;
  logic              ph_zero_unused, vec_zero_unused;

  function automatic logic [PH_W-1:0] len_of(input state_e s);
    case (s)
      S_KLOAD:  len_of = PH_W'(col);
      S_KFLUSH: len_of = PH_W'(row);
      S_DRAIN:  len_of = PH_W'(DRAIN_LEN);
      default:  len_of = '0;
    endcase
  endfunction

  // Phase length counter (kernel load, flush, drain).
  mac_ctrl_cnt #(.W(PH_W)) u_ph_cnt (
    .clk(clk), .rst(reset), .load(ph_load), .load_val(ph_val), .en(ph_en),
    .count(ph_cnt), .zero(ph_zero_unused)
  );

  // Remaining-vector counter for the execute phase.
  mac_ctrl_cnt #(.W(cnt_bw)) u_vec_cnt (
    .clk(clk), .rst(reset), .load(vec_load), .load_val(vec_val), .en(vec_en),
    .count(vec_cnt), .zero(vec_zero_unused)
  );

  // Decide next-cycle outputs, phase advance and counter updates.
  always_comb begin
    start_acc = (state_q == S_IDLE) && start;
    mode_eff  = start_acc ? mode : mode_q;
    nv_eff    = start_acc ? num_vec : num_vec_q;
    nv_zero   = (nv_eff == '0);
    if (start_acc) begin
      cur_ph = mode ? (nv_zero ? S_DRAIN : S_EXEC) : S_KLOAD;
    end else begin
      cur_ph = state_q;
    end
    ph_rem  = start_acc ? len_of(cur_ph) : ph_cnt;
    vec_rem = start_acc ? num_vec : vec_cnt;

    go     = 1'b0;
    last   = 1'b0;
    nxt_ph = cur_ph;
    case (cur_ph)
      S_KLOAD: begin
        go     = ~ififo_empty;
        last   = go && (ph_rem == PH_ONE);
        nxt_ph = S_KFLUSH;
      end
      S_KFLUSH: begin
        go     = 1'b1;
        last   = (ph_rem == PH_ONE);
        nxt_ph = nv_zero ? S_DRAIN : S_EXEC;
      end
      S_EXEC: begin
        go     = ~ififo_empty & ~(|ofifo_full);
        last   = go && (vec_rem == VEC_ONE);
        nxt_ph = S_DRAIN;
      end
      S_DRAIN: begin
        go     = 1'b1;
        last   = (ph_rem == PH_ONE);
        nxt_ph = S_DONE;
      end
      S_DONE: begin
        go     = 1'b1;
        last   = 1'b1;
        nxt_ph = S_IDLE;
      end
      default: begin
        go     = 1'b0;
        last   = 1'b0;
        nxt_ph = S_IDLE;
      end
    endcase
    state_d = last ? nxt_ph : cur_ph;

    ph_load = 1'b0;
    ph_en   = 1'b0;
    ph_val  = '0;
    if (last) begin
      ph_load = 1'b1;
      ph_val  = len_of(nxt_ph);
    end else if (start_acc) begin
      ph_load = 1'b1;
      ph_val  = ph_rem - {{(PH_W-1){1'b0}}, (go && (cur_ph != S_EXEC))};
    end else begin
      ph_en = go && (cur_ph != S_EXEC);
    end

    vec_load = 1'b0;
    vec_en   = 1'b0;
    vec_val  = '0;
    if (start_acc) begin
      vec_load = 1'b1;
      vec_val  = vec_rem - {{(cnt_bw-1){1'b0}}, (go && (cur_ph == S_EXEC))};
    end else if ((cur_ph == S_KFLUSH) && last) begin
      vec_load = 1'b1;
      vec_val  = num_vec_q;
    end else begin
      vec_en = go && (cur_ph == S_EXEC);
    end

    busy_d    = (cur_ph != S_IDLE);
    done_d    = (cur_ph == S_DONE);
    wo_d      = busy_d & mode_eff;
    inst_w_d  = INST_NOP;
    if (go && (cur_ph == S_KLOAD)) inst_w_d = INST_KLOAD;
    if (go && (cur_ph == S_EXEC))  inst_w_d = INST_EXEC;
    ovf_d     = start_acc ? 1'b0 : (ovf_q | (|(arr_valid & ofifo_full)));
    mode_d    = mode_eff;
    num_vec_d = nv_eff;
  end

  // FSM state, latched job parameters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      num_vec_q <= '0;
      inst_w_q  <= INST_NOP;
      wo_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      num_vec_q <= num_vec_d;
      inst_w_q  <= inst_w_d;
      wo_q      <= wo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign inst_w        = inst_w_q;
  assign weight_or_out = wo_q;
  assign ififo_rd      = |inst_w_q;
  assign ofifo_wr      = arr_valid & ~ofifo_full;
  assign busy          = busy_q;
  assign done          = done_q;
  assign ovf           = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Bench for mac_array_ctrl: per-cycle comparison against a phase/progress model,
// directed jobs with hand-computed timing, and randomized jobs.
module tb_mac_array_ctrl;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int CBW  = 8;
  localparam int DLEN = ROW + COL + 1;

  localparam int K_PLAIN = 0, K_EMPTY = 1, K_OVF = 2, K_RAND = 3, K_IGN = 4, K_RST = 5;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic           start, mode, ififo_empty;
  logic [CBW-1:0] num_vec;
  logic [COL-1:0] ofifo_full, arr_valid, ofifo_wr;
  logic [1:0]     inst_w;
  logic           weight_or_out, ififo_rd, busy, done, ovf;
  logic [2:0]     dbg_state;

  always #5 clk = ~clk;

  mac_array_ctrl #(.row(ROW), .col(COL), .cnt_bw(CBW)) dut (
    .clk(clk), .reset(rst), .start(start), .mode(mode), .num_vec(num_vec),
    .ififo_empty(ififo_empty), .ofifo_full(ofifo_full), .arr_valid(arr_valid),
    .inst_w(inst_w), .weight_or_out(weight_or_out), .ififo_rd(ififo_rd),
    .ofifo_wr(ofifo_wr), .busy(busy), .done(done), .ovf(ovf), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  // m_ph: 0 idle, 1 kernel load, 2 flush, 3 execute, 4 drain, 5 done.
  // m_prog counts work completed in the current phase.
  int         m_ph = 0, m_prog = 0, m_nv = 0, job_cyc = 0;
  logic       m_mode = 1'b0;
  logic [1:0] e_inst;
  logic       e_wo, e_busy, e_done, e_ovf = 1'b0;
  logic [6:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_prog = 0; m_nv = 0; m_mode = 1'b0; e_ovf = 1'b0;
      exp_q.delete();
    end else begin
      job_cyc++;
      if (m_ph == 0 && start) begin
        job_cyc = 1;
        m_mode  = mode;
        m_nv    = int'(num_vec);
        m_ph    = mode ? ((num_vec == 0) ? 4 : 3) : 1;
        m_prog  = 0;
        e_ovf   = 1'b0;
      end else begin
        e_ovf = e_ovf | (|(arr_valid & ofifo_full));
      end
      e_busy = (m_ph != 0);
      e_done = (m_ph == 5);
      e_wo   = e_busy & m_mode;
      e_inst = 2'b00;
      case (m_ph)
        1: if (!ififo_empty) begin
             e_inst = 2'b01; m_prog++;
             if (m_prog == COL) begin m_ph = 2; m_prog = 0; end
           end
        2: begin
             m_prog++;
             if (m_prog == ROW) begin m_ph = (m_nv == 0) ? 4 : 3; m_prog = 0; end
           end
        3: if (!ififo_empty && ofifo_full == 0) begin
             e_inst = 2'b10; m_prog++;
             if (m_prog == m_nv) begin m_ph = 4; m_prog = 0; end
           end
        4: begin
             m_prog++;
             if (m_prog == DLEN) begin m_ph = 5; m_prog = 0; end
           end
        5: m_ph = 0;
        default: ;
      endcase
      exp_q.push_back({e_inst, (e_inst != 2'b00), e_wo, e_busy, e_done, e_ovf});
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [14:0] act_v, exp_v;
  int  done_cyc, rd_cnt, kl_cnt, ex_cnt;
  bit  done_seen;

  always @(negedge clk) begin
    act_v = {inst_w, ififo_rd, weight_or_out, busy, done, ovf, ofifo_wr};
    if (rst || exp_q.size() == 0) exp_v = {7'b0, arr_valid & ~ofifo_full};
    else                          exp_v = {exp_q.pop_front(), arr_valid & ~ofifo_full};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL outs t=%0t job_cyc=%0d act=%b exp=%b (inst,rd,wo,busy,done,ovf,wr)",
               $time, job_cyc, act_v, exp_v);
    end
    if (!rst) begin
      if (done === 1'b1) begin done_seen = 1'b1; done_cyc = job_cyc; end
      rd_cnt += int'(ififo_rd === 1'b1);
      kl_cnt += int'(inst_w === 2'b01);
      ex_cnt += int'(inst_w === 2'b10);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_job(input logic md, input int nv, input int kind, input int exp_done,
                         input int exp_rd, input int exp_kl, input int exp_ex);
    int  i;
    bit  aborted;
    @(posedge clk); #1;
    start = 1'b1; mode = md; num_vec = CBW'(nv);
    ififo_empty = 1'b0; ofifo_full = '0; arr_valid = '0;
    done_seen = 1'b0; done_cyc = 0; rd_cnt = 0; kl_cnt = 0; ex_cnt = 0;
    aborted = 1'b0;
    i = 0;
    while (!done_seen && !aborted && i < 200) begin
      @(posedge clk); #1;
      i++;
      start       = 1'b0;
      mode        = 1'($urandom_range(0, 1));
      num_vec     = CBW'($urandom_range(0, 255));
      ififo_empty = 1'b0;
      ofifo_full  = '0;
      arr_valid   = COL'($urandom);
      case (kind)
        K_EMPTY: ififo_empty = (job_cyc >= 17 && job_cyc <= 19);
        K_OVF: if (job_cyc >= 25 && job_cyc <= 27) begin
                 arr_valid = 8'h01; ofifo_full = 8'h01;
               end
        K_RAND: begin
                  ififo_empty = ($urandom_range(0, 3) == 0);
                  ofifo_full  = ($urandom_range(0, 5) == 0) ? COL'($urandom) : '0;
                  start       = (job_cyc >= 2 && job_cyc <= 15 && $urandom_range(0, 7) == 0);
                end
        K_IGN: start = (job_cyc == 5);
        K_RST: begin
                 if (job_cyc == 1) chk("ovf_clear_on_start", int'(ovf), 0);
                 if (job_cyc == 19) begin
                   arr_valid = '0;
                   #2 rst = 1'b1;
                   #1 chk("abort_outputs_zero",
                          int'({inst_w, ififo_rd, weight_or_out, ofifo_wr, busy, done, ovf}), 0);
                   @(posedge clk); #1 rst = 1'b0;
                   aborted = 1'b1;
                 end
               end
        default: ;
      endcase
    end
    start = 1'b0; arr_valid = '0; ofifo_full = '0; ififo_empty = 1'b0;
    if (!aborted) begin
      chk("done_seen", int'(done_seen), 1);
      if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
      chk("ififo_rd_pulses", rd_cnt, exp_rd);
      chk("kload_issues", kl_cnt, exp_kl);
      chk("exec_issues", ex_cnt, exp_ex);
    end
    repeat (2) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int md, nv;
    rst = 1'b1; start = 1'b0; mode = 1'b0; num_vec = '0;
    ififo_empty = 1'b0; ofifo_full = '0; arr_valid = '0;
    #22 rst = 1'b0;
    #1 chk("reset_outputs",
           int'({inst_w, ififo_rd, weight_or_out, ofifo_wr, busy, done, ovf}), 0);

    run_job(1'b0, 4, K_PLAIN, 38, 12, 8, 4);   // WS, 4 vectors
    run_job(1'b0, 4, K_EMPTY, 41, 12, 8, 4);   // WS with IFIFO starved 3 cycles
    run_job(1'b1, 8, K_PLAIN, 26, 8, 0, 8);    // OS, 8 vectors
    run_job(1'b0, 4, K_OVF,   38, 12, 8, 4);   // overflow during drain
    repeat (3) @(posedge clk);
    #1 chk("ovf_held_idle", int'(ovf), 1);
    run_job(1'b0, 4, K_RST,   -1, 0, 0, 0);    // reset mid-execute
    run_job(1'b0, 4, K_PLAIN, 38, 12, 8, 4);   // clean job after abort
    run_job(1'b0, 0, K_IGN,   34, 8, 8, 0);    // WS, no vectors, stray start
    run_job(1'b1, 0, K_PLAIN, 18, 0, 0, 0);    // OS, no vectors

    for (int j = 0; j < 10; j++) begin
      md = $urandom_range(0, 1);
      nv = $urandom_range(0, 12);
      run_job(1'(md), nv, K_RAND, -1, (md != 0 ? 0 : COL) + nv, (md != 0 ? 0 : COL), nv);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
